instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Sequential instruction fetch front-end with a 2-entry {instr, pc} buffer.
//   Keeps at most two instructions buffered or in flight so the buffer can
//   never overflow. Execute-stage redirects flush everything and restart
//   fetch at the word-aligned target.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous active-high reset
//   imem_req       : read request to instruction memory this cycle
//   imem_addr      : word-aligned read address (equals fetch_pc)
//   imem_rvalid    : read data valid, one cycle after each imem_req
//   imem_rdata     : instruction word returned by memory
//   redirect_valid : branch/jump redirect from execute
//   redirect_pc    : redirect target
//   instr_valid    : buffered instruction available to the decoder
//   instr          : instruction word at the buffer head
//   instr_pc       : PC of instr
//   instr_ready    : decoder accepts instr this cycle
//   fetch_pc       : address of the next request to issue
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] fetch_pc
);

  // Entry 0 is always the head, so instr/instr_pc come straight from flops.
  logic [31:0] e0_instr_q, e0_instr_d;
  logic [31:0] e0_pc_q,    e0_pc_d;
  logic [31:0] e1_instr_q, e1_instr_d;
  logic [31:0] e1_pc_q,    e1_pc_d;
  logic [1:0]  count_q,    count_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;

  logic        pop;
  logic        push;
  logic        req;
  logic [2:0]  occupancy;

  assign pop       = (count_q != 2'd0) && instr_ready;
  // Buffered plus in-flight entries after this cycle's pop; a new request is
  // only allowed if its response is guaranteed a free slot.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign req       = !reset && !redirect_valid && (occupancy < 3'd2);
  // Responses are only accepted for a request we still consider live; a
  // redirect or reset clears inflight_q and thereby drops its response.
  assign push      = imem_rvalid && inflight_q;

  always_comb begin
    e0_instr_d    = e0_instr_q;
    e0_pc_d       = e0_pc_q;
    e1_instr_d    = e1_instr_q;
    e1_pc_d       = e1_pc_q;
    count_d       = count_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    fetch_pc_d    = fetch_pc_q;

    if (redirect_valid) begin
      count_d    = 2'd0;
      inflight_d = 1'b0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      inflight_d    = req;
      inflight_pc_d = fetch_pc_q;
      if (req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end

      unique case ({pop, push})
        2'b10: begin
          e0_instr_d = e1_instr_q;
          e0_pc_d    = e1_pc_q;
          count_d    = count_q - 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd0) begin
            e0_instr_d = imem_rdata;
            e0_pc_d    = inflight_pc_q;
          end else begin
            e1_instr_d = imem_rdata;
            e1_pc_d    = inflight_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_instr_d = imem_rdata;
            e0_pc_d    = inflight_pc_q;
          end else begin
            e0_instr_d = e1_instr_q;
            e0_pc_d    = e1_pc_q;
            e1_instr_d = imem_rdata;
            e1_pc_d    = inflight_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e0_instr_q    <= 32'd0;
      e0_pc_q       <= 32'd0;
      e1_instr_q    <= 32'd0;
      e1_pc_q       <= 32'd0;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      fetch_pc_q    <= RESET_PC;
    end else begin
      e0_instr_q    <= e0_instr_d;
      e0_pc_q       <= e0_pc_d;
      e1_instr_q    <= e1_instr_d;
      e1_pc_q       <= e1_pc_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = fetch_pc_q;
  assign fetch_pc    = fetch_pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = e0_instr_q;
  assign instr_pc    = e0_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [31:0] fetch_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fetch_pc       (fetch_pc)
  );

  int vectors = 0;
  int errors  = 0;
  int mem_mode = 0;   // 0: mem[0]=0x33, mem[4]=0x13, else addr; 1: data = addr

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_mode == 0 && a == 32'h0) return 32'h0000_0033;
    if (mem_mode == 0 && a == 32'h4) return 32'h0000_0013;
    return a;
  endfunction

  // Memory model: returns data exactly one cycle after each request.
  logic        cap_req;
  logic [31:0] cap_addr;

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    cap_req  = imem_req;
    cap_addr = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = cap_req;
    imem_rdata  = cap_req ? mem_rd(cap_addr) : $urandom;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        chk;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] einstr;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic c, input logic ereq, input logic [31:0] eaddr,
                     input logic evalid, input logic [31:0] einstr, input logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.chk = c;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.einstr = einstr; v.epc = epc;
    tbl.push_back(v);
  endtask

  // Reference model state for the random phase.
  logic [63:0] mq[$];   // {instr, pc}
  int          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_fpc;
  logic [31:0] exp_next;

  initial begin
    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;

    //   rst rdy rdr rpc           chk req addr          vld instr         pc
    add(1, 0, 0, 0,               0, 0, 0,              0, 0,            0);
    add(1, 0, 0, 0,               1, 0, 0,              0, 0,            0);
    // start-up with decoder stalled for six cycles, then streaming
    add(0, 0, 0, 0,               1, 1, 32'h0,          0, 0,            0);
    add(0, 0, 0, 0,               1, 1, 32'h4,          0, 0,            0);
    add(0, 0, 0, 0,               1, 0, 0,              1, 32'h33,       32'h0);
    add(0, 0, 0, 0,               1, 0, 0,              1, 32'h33,       32'h0);
    add(0, 0, 0, 0,               1, 0, 0,              1, 32'h33,       32'h0);
    add(0, 0, 0, 0,               1, 0, 0,              1, 32'h33,       32'h0);
    add(0, 1, 0, 0,               1, 1, 32'h8,          1, 32'h33,       32'h0);
    add(0, 1, 0, 0,               1, 1, 32'hC,          1, 32'h13,       32'h4);
    add(0, 1, 0, 0,               1, 1, 32'h10,         1, 32'h8,        32'h8);
    add(0, 1, 0, 0,               1, 1, 32'h14,         1, 32'hC,        32'hC);
    // redirect to 0x8 and fill the buffer with 0x8/0xC
    add(0, 0, 1, 32'h8,           1, 0, 0,              1, 32'h10,       32'h10);
    add(0, 0, 0, 0,               1, 1, 32'h8,          0, 0,            0);
    add(0, 0, 0, 0,               1, 1, 32'hC,          0, 0,            0);
    add(0, 0, 0, 0,               1, 0, 0,              1, 32'h8,        32'h8);
    add(0, 0, 0, 0,               1, 0, 0,              1, 32'h8,        32'h8);
    // redirect while full
    add(0, 0, 1, 32'h100,         1, 0, 0,              1, 32'h8,        32'h8);
    add(0, 1, 0, 0,               1, 1, 32'h100,        0, 0,            0);
    add(0, 1, 0, 0,               1, 1, 32'h104,        0, 0,            0);
    add(0, 1, 0, 0,               1, 1, 32'h108,        1, 32'h100,      32'h100);
    add(0, 1, 0, 0,               1, 1, 32'h10C,        1, 32'h104,      32'h104);
    // unaligned target
    add(0, 1, 1, 32'h102,         1, 0, 0,              1, 32'h108,      32'h108);
    add(0, 1, 0, 0,               1, 1, 32'h100,        0, 0,            0);
    add(0, 1, 0, 0,               1, 1, 32'h104,        0, 0,            0);
    add(0, 1, 0, 0,               1, 1, 32'h108,        1, 32'h100,      32'h100);
    // wrap-around target
    add(0, 1, 1, 32'hFFFF_FFFC,   1, 0, 0,              1, 32'h104,      32'h104);
    add(0, 1, 0, 0,               1, 1, 32'hFFFF_FFFC,  0, 0,            0);
    add(0, 1, 0, 0,               1, 1, 32'h0,          0, 0,            0);
    add(0, 1, 0, 0,               1, 1, 32'h4,          1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    add(0, 1, 0, 0,               1, 1, 32'h8,          1, 32'h33,       32'h0);
    // reset with a request in flight: its response must be dropped
    add(1, 0, 0, 0,               1, 0, 0,              1, 32'h13,       32'h4);
    add(0, 1, 0, 0,               1, 1, RST_PC,         0, 0,            0);
    add(0, 1, 0, 0,               1, 1, 32'h4,          0, 0,            0);
    add(0, 1, 0, 0,               1, 1, 32'h8,          1, 32'h33,       32'h0);
    add(0, 1, 0, 0,               1, 1, 32'hC,          1, 32'h13,       32'h4);
    // reset beats a simultaneous redirect
    add(1, 1, 1, 32'h200,         1, 0, 0,              1, 32'h8,        32'h8);
    add(0, 1, 0, 0,               1, 1, RST_PC,         0, 0,            0);
    add(0, 1, 0, 0,               1, 1, 32'h4,          0, 0,            0);
    add(0, 1, 0, 0,               1, 1, 32'h8,          1, 32'h33,       32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; instr_ready = tbl[i].rdy;
      redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
      settle();
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].ereq});
        if (tbl[i].ereq) begin
          chk($sformatf("tbl%0d imem_addr", i), imem_addr, tbl[i].eaddr);
          chk($sformatf("tbl%0d fetch_pc", i), fetch_pc, tbl[i].eaddr);
        end
        chk($sformatf("tbl%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].evalid});
        if (tbl[i].evalid) begin
          chk($sformatf("tbl%0d instr", i), instr, tbl[i].einstr);
          chk($sformatf("tbl%0d instr_pc", i), instr_pc, tbl[i].epc);
        end
      end
      advance();
    end

    // Random phase: memory returns its address, decoder ready 50%, rare
    // redirects and resets, every output checked against a queue model.
    mem_mode = 1;
    m_infl = 0; m_infl_pc = 32'h0; m_fpc = RST_PC; exp_next = RST_PC;
    for (int i = 0; i < 1200; i++) begin
      logic r_rst, r_redir, r_rdy, e_valid, e_pop, e_req;
      logic [31:0] r_rpc;
      r_rst   = (i < 2) || ($urandom_range(0, 199) == 0);
      r_redir = ($urandom_range(0, 49) == 0);
      r_rpc   = $urandom;
      r_rdy   = $urandom_range(0, 1) == 1;
      reset = r_rst; redirect_valid = r_redir; redirect_pc = r_rpc; instr_ready = r_rdy;
      settle();

      e_valid = (mq.size() != 0);
      e_pop   = e_valid && r_rdy;
      e_req   = !r_rst && !r_redir && ((mq.size() + m_infl - (e_pop ? 1 : 0)) < 2);

      if (i > 0) begin
        chk("rnd imem_req", {31'd0, imem_req}, {31'd0, e_req});
        chk("rnd fetch_pc", fetch_pc, m_fpc);
        if (e_req) chk("rnd imem_addr", imem_addr, m_fpc);
        chk("rnd instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
        if (e_valid) begin
          chk("rnd instr", instr, mq[0][63:32]);
          chk("rnd instr_pc", instr_pc, mq[0][31:0]);
        end
        if (!r_rst && !r_redir && instr_valid && r_rdy) begin
          chk("rnd data==pc", instr, instr_pc);
          chk("rnd pc sequence", instr_pc, exp_next);
          exp_next = exp_next + 32'd4;
        end
      end

      if (r_rst) begin
        mq.delete(); m_infl = 0; m_fpc = RST_PC; exp_next = RST_PC;
      end else if (r_redir) begin
        mq.delete(); m_infl = 0; m_fpc = {r_rpc[31:2], 2'b00}; exp_next = m_fpc;
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (m_infl != 0) mq.push_back({mem_rd(m_infl_pc), m_infl_pc});
        m_infl    = e_req ? 1 : 0;
        m_infl_pc = m_fpc;
        if (e_req) m_fpc = m_fpc + 32'd4;
      end
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
